// File: rtl/prio_encoder_8_3.sv
// Sequential priority encoder: sticky pending requests, masked priority pick,
// registered code with a valid/ready handshake that clears the accepted line.
module prio_encoder_8_3 #(
    parameter int N        = 8,
    parameter int W        = 3,
    parameter int LOW_WINS = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic [N-1:0] mask,
    output logic [W-1:0] code,
    output logic         valid,
    input  logic         ready,
    output logic [N-1:0] pending
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   code_q, code_d;
    logic           valid_q, valid_d;
    logic [N-1:0]   pending_q, pending_d;

    logic           fire;
    logic [N-1:0]   clr;
    logic [N-1:0]   cand;
    logic           any_cand;
    logic [W-1:0]   sel;

    assign fire      = valid_q & ready;
    assign clr       = fire ? (N'(1) << code_q) : '0;
    // A new request on the line being cleared wins, so it is served again later.
    assign pending_d = (pending_q & ~clr) | req;
    assign cand      = pending_d & ~mask;
    assign any_cand  = |cand;

    always_comb begin
        sel = '0;
        if (LOW_WINS != 0) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (cand[i]) sel = W'(i);
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (cand[i]) sel = W'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (any_cand) begin
                    code_d  = sel;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // Code is frozen until accepted; a fire reloads it in the same edge.
                if (fire) begin
                    if (any_cand) begin
                        code_d = sel;
                    end else begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            code_q    <= '0;
            valid_q   <= 1'b0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            pending_q <= pending_d;
        end
    end

    assign code    = code_q;
    assign valid   = valid_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_prio_encoder_8_3.sv
// Bench for prio_encoder_8_3: cycle table plus accepted-code scoreboards for a
// low-wins and a high-wins instance driven by the same stimulus.
module tb_prio_encoder_8_3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = '0;
    logic [7:0] mask = '0;
    logic       ready = 1'b0;

    logic [2:0] code_lo, code_hi;
    logic       valid_lo, valid_hi;
    logic [7:0] pending_lo, pending_hi;

    int n_checks = 0;
    int n_fail   = 0;

    int q_lo[$];
    int q_hi[$];

    always #5 clk = ~clk;

    prio_encoder_8_3 #(.N(8), .W(3), .LOW_WINS(1)) dut_lo (
        .clk(clk), .rst(rst), .req(req), .mask(mask),
        .code(code_lo), .valid(valid_lo), .ready(ready), .pending(pending_lo)
    );

    prio_encoder_8_3 #(.N(8), .W(3), .LOW_WINS(0)) dut_hi (
        .clk(clk), .rst(rst), .req(req), .mask(mask),
        .code(code_hi), .valid(valid_hi), .ready(ready), .pending(pending_hi)
    );

    typedef struct {
        logic [7:0] req;
        logic [7:0] mask;
        logic       ready;
        logic       exp_valid;
        logic [2:0] exp_code;
        logic [7:0] exp_pend;
    } vec_t;

    vec_t vecs[24];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic step(input logic [7:0] r, input logic [7:0] m, input logic rd);
        req   = r;
        mask  = m;
        ready = rd;
        @(posedge clk);
        #1;
    endtask

    // A fire seen here is the acceptance taken by the next rising edge.
    always @(negedge clk) begin
        if (!rst && valid_lo && ready) begin
            if (q_lo.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL accept_lo: got unexpected code %0d expected none", code_lo);
            end else begin
                chk("accept_lo", int'(code_lo), q_lo.pop_front());
            end
        end
        if (!rst && valid_hi && ready) begin
            if (q_hi.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL accept_hi: got unexpected code %0d expected none", code_hi);
            end else begin
                chk("accept_hi", int'(code_hi), q_hi.pop_front());
            end
        end
    end

    initial begin
        // single request
        vecs[0]  = '{8'h20, 8'h00, 1'b1, 1'b1, 3'd5, 8'h20};
        vecs[1]  = '{8'h00, 8'h00, 1'b1, 1'b0, 3'd5, 8'h00};
        // priority, back-to-back
        vecs[2]  = '{8'h91, 8'h00, 1'b1, 1'b1, 3'd0, 8'h91};
        vecs[3]  = '{8'h00, 8'h00, 1'b1, 1'b1, 3'd4, 8'h90};
        vecs[4]  = '{8'h00, 8'h00, 1'b1, 1'b1, 3'd7, 8'h80};
        vecs[5]  = '{8'h00, 8'h00, 1'b1, 1'b0, 3'd7, 8'h00};
        // stall with req and mask changes
        vecs[6]  = '{8'h08, 8'h00, 1'b0, 1'b1, 3'd3, 8'h08};
        vecs[7]  = '{8'h01, 8'hFF, 1'b0, 1'b1, 3'd3, 8'h09};
        vecs[8]  = '{8'h00, 8'h00, 1'b0, 1'b1, 3'd3, 8'h09};
        vecs[9]  = '{8'h00, 8'h08, 1'b0, 1'b1, 3'd3, 8'h09};
        vecs[10] = '{8'h00, 8'h00, 1'b0, 1'b1, 3'd3, 8'h09};
        vecs[11] = '{8'h00, 8'h00, 1'b1, 1'b1, 3'd0, 8'h01};
        vecs[12] = '{8'h00, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00};
        // set wins over clear
        vecs[13] = '{8'h04, 8'h00, 1'b0, 1'b1, 3'd2, 8'h04};
        vecs[14] = '{8'h04, 8'h00, 1'b1, 1'b1, 3'd2, 8'h04};
        vecs[15] = '{8'h00, 8'h00, 1'b1, 1'b0, 3'd2, 8'h00};
        // masking
        vecs[16] = '{8'h0C, 8'h0C, 1'b1, 1'b0, 3'd2, 8'h0C};
        vecs[17] = '{8'h00, 8'h0C, 1'b1, 1'b0, 3'd2, 8'h0C};
        vecs[18] = '{8'h00, 8'h04, 1'b1, 1'b1, 3'd3, 8'h0C};
        vecs[19] = '{8'h00, 8'h04, 1'b1, 1'b0, 3'd3, 8'h04};
        vecs[20] = '{8'h00, 8'h00, 1'b1, 1'b1, 3'd2, 8'h04};
        vecs[21] = '{8'h00, 8'h00, 1'b1, 1'b0, 3'd2, 8'h00};
        // idle with ready high is ignored
        vecs[22] = '{8'h00, 8'h00, 1'b1, 1'b0, 3'd2, 8'h00};
        vecs[23] = '{8'h00, 8'h00, 1'b0, 1'b0, 3'd2, 8'h00};

        // reset state
        #12;
        chk("rst_valid", int'(valid_lo), 0);
        chk("rst_code", int'(code_lo), 0);
        chk("rst_pending", int'(pending_lo), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // async reset in the middle of a hold
        step(8'h06, 8'h00, 1'b0);
        chk("hold_valid", int'(valid_lo), 1);
        chk("hold_code_lo", int'(code_lo), 1);
        chk("hold_code_hi", int'(code_hi), 2);
        chk("hold_pending", int'(pending_lo), 8'h06);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", int'(valid_lo), 0);
        chk("arst_code", int'(code_lo), 0);
        chk("arst_pending", int'(pending_lo), 0);
        chk("arst_valid_hi", int'(valid_hi), 0);
        rst = 1'b0;
        step(8'h00, 8'h00, 1'b1);
        step(8'h00, 8'h00, 1'b1);
        chk("post_rst_valid", int'(valid_lo), 0);
        chk("post_rst_pending", int'(pending_lo), 0);

        // expected acceptance order for the whole table
        q_lo = '{5, 0, 4, 7, 3, 0, 2, 2, 3, 2};
        q_hi = '{5, 7, 4, 0, 3, 0, 2, 2, 3, 2};
        for (int i = 0; i < 24; i++) begin
            step(vecs[i].req, vecs[i].mask, vecs[i].ready);
            chk($sformatf("v%0d_valid", i), int'(valid_lo), int'(vecs[i].exp_valid));
            chk($sformatf("v%0d_code", i), int'(code_lo), int'(vecs[i].exp_code));
            chk($sformatf("v%0d_pending", i), int'(pending_lo), int'(vecs[i].exp_pend));
        end
        chk("hi_final_valid", int'(valid_hi), 0);
        chk("hi_final_pending", int'(pending_hi), 0);
        chk("sb_lo_left", q_lo.size(), 0);
        chk("sb_hi_left", q_hi.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prio_encoder_8_3.md
Name: prio_encoder_8_3

Overview:
- Sequential 8-to-3 priority encoder with a valid/ready output handshake. It is the inverse companion of the 3-to-8 decoder.
- Captures request pulses on 8 lines into a sticky pending register. Presents the index of the highest-priority unmasked pending request as a binary code. Clears that request when the consumer accepts it.
- Used as an interrupt/event arbiter front end. Its code output can drive the decoder directly to regenerate a one-hot acknowledge.

Parameters:
- N, 8, number of request lines.
- W, 3, code width; must equal clog2(N).
- LOW_WINS, 1, 1: lowest index has highest priority; 0: highest index wins.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  request pulses, sampled every clk edge; a 1 sets the matching pending bit.
- mask  input  N  1 = line blocked from selection; its pending bit is still retained.
- code  output  W  encoded index of the selected request; valid only while valid=1.
- valid  output  1  code holds an unaccepted request.
- ready  input  1  consumer accepts code on a clk edge where valid=1 and ready=1.
- pending  output  N  current pending register, for status and debug.

Behaviour:
- Reset (async, immediate on rst=1): pending=0, code=0, valid=0, state=IDLE. No clk edge is needed. Reset asserted mid-handshake drops the transaction; nothing is accepted.
- Define:
  - fire = valid & ready.
  - clr = one-hot(code) when fire, else 0.
  - pending_nxt = (pending & ~clr) | req.
  - Set wins: if req[i]=1 on the same edge that clears bit i, bit i stays 1 and is served again later.
- Each edge: pending <= pending_nxt.
- Selection: cand = pending_nxt & ~mask. Priority search over cand per LOW_WINS. Combinational; the result is registered into code.
- State machine:
  - IDLE (valid=0): if cand != 0, load code with the selected index, valid <= 1, go to HOLD. Otherwise stay.
  - HOLD (valid=1): code and valid stay stable while ready=0. Changes to mask, req or pending do not alter code. No retraction.
  - On fire with cand != 0: load the next code on the same edge and stay in HOLD, valid stays 1. This gives back-to-back throughput of one acceptance per clk.
  - On fire with cand == 0: valid <= 0, go to IDLE.
- Latency:
  - req high at edge t: code/valid are updated at the same edge t when in IDLE, because cand uses pending_nxt. valid is visible in the cycle after edge t.
  - Minimum req-to-acceptance is 2 edges.
- Masking:
  - A masked pending bit never gets selected.
  - Unmasking makes it eligible at the next selection point: the next IDLE edge or the next fire.
  - If all pending bits are masked, valid stays 0.
- A repeated req on an already-pending bit has no further effect. There is no counting; requests coalesce.
- code is a registered output with no glitches. When valid=0, code holds its last value (0 after reset).
- ready while valid=0 is ignored.

Test Plan:
- Reset mid-HOLD: with pending=8'h06, valid=1, assert rst asynchronously between edges -> valid=0, code=0, pending=0 immediately. After release with req=0, valid stays 0.
- Single request: req=8'h20 for 1 cycle, ready=1 -> next cycle valid=1, code=5. It is accepted at the following edge, then valid=0 and pending=0.
- Priority + back-to-back: req=8'h91 in one cycle, ready=1, LOW_WINS=1 -> codes 0,4,7 accepted on 3 consecutive edges with valid continuous, then valid=0. With LOW_WINS=0 -> order 7,4,0.
- Stall stability: req=8'h08, ready=0 for 5 cycles, then req=8'h01 and mask toggled during the stall -> code stays 3 with valid=1 throughout. After ready=1, code 3 is accepted, then code 0 is presented.
- Set-wins collision: code=2 in HOLD, ready=1 and req=8'h04 on the same edge -> pending[2] stays 1, and code 2 is presented again on the next edge.
- Masking: req=8'h0C, mask=8'h0C -> valid stays 0 and pending=8'h0C. Set mask=8'h04 -> code=3 is presented and accepted. Set mask=0 -> code=2 is presented.
